// File: rtl/shiftreg_pkg.sv
// Shared definitions for the shift-register transmitter/receiver pair.
// Holds the FSM state encodings and the counter-width helper.
package shiftreg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/shiftreg_tx.sv
// Parallel-in/serial-out transmitter: valid/ready word load, MSB-first bit stream, done on the last bit.
// Optional even-parity trailer bit enabled by defining SHIFTREG_TX_PARITY_EN.
module shiftreg_tx
  import shiftreg_pkg::*;
#(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             databit,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = clog2(WIDTH);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [WIDTH-1:0] r_sreg;
  logic [CW-1:0]  r_cnt;
  logic           w_last;
  logic           w_accept;
`ifdef SHIFTREG_TX_PARITY_EN
  logic           r_par;
`endif

  assign w_last   = (r_cnt == '0);
  assign w_accept = load_valid && load_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Outputs decode only registered state; load_valid steers next state alone.
  always_comb begin
    w_state_nxt = r_state;
    load_ready  = 1'b0;
    databit     = IDLE_BIT;
    bit_valid   = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        load_ready = 1'b1;
        if (load_valid) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        databit   = r_sreg[WIDTH-1];
        bit_valid = 1'b1;
        busy      = 1'b1;
        if (w_last) begin
`ifdef SHIFTREG_TX_PARITY_EN
          w_state_nxt = ST_PARITY;
`else
          load_ready  = 1'b1;
          done        = 1'b1;
          w_state_nxt = load_valid ? ST_SHIFT : ST_IDLE;
`endif
        end
      end
`ifdef SHIFTREG_TX_PARITY_EN
      ST_PARITY: begin
        databit     = r_par;
        bit_valid   = 1'b1;
        busy        = 1'b1;
        done        = 1'b1;
        load_ready  = 1'b1;
        w_state_nxt = load_valid ? ST_SHIFT : ST_IDLE;
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_cnt  <= '0;
`ifdef SHIFTREG_TX_PARITY_EN
      r_par  <= 1'b0;
`endif
    end else if (w_accept) begin
      r_sreg <= data_in;
      r_cnt  <= CW'(WIDTH - 1);
`ifdef SHIFTREG_TX_PARITY_EN
      r_par  <= ^data_in;
`endif
    end else if (r_state == ST_SHIFT) begin
      r_sreg <= {r_sreg[WIDTH-2:0], 1'b0};
      // Counter parks at zero until the next accept reloads it.
      if (!w_last) r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule
